// File: rtl/dnn_out_stage.sv
// Output layer of the dnn pipeline: two 4-input MAC neurons (nodes 8 and 9) with
// optional ReLU and a one-entry input buffer so vectors can stream back-to-back.
module dnn_out_stage #(
   parameter bit RELU_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stg_2_rdy,
   input  logic signed [20:0] y0,
   input  logic signed [20:0] y1,
   input  logic signed [20:0] y2,
   input  logic signed [20:0] y3,
   input  logic signed [4:0]  w48,
   input  logic signed [4:0]  w58,
   input  logic signed [4:0]  w68,
   input  logic signed [4:0]  w78,
   input  logic signed [4:0]  w49,
   input  logic signed [4:0]  w59,
   input  logic signed [4:0]  w69,
   input  logic signed [4:0]  w79,
   output logic signed [27:0] z0,
   output logic signed [27:0] z1,
   output logic               stg_3_rdy,
   output logic               busy,
   output logic               overrun
);

   typedef enum logic {ST_IDLE, ST_MAC} state_t;

   state_t             state;
   logic [1:0]         cnt;
   logic signed [27:0] acc0, acc1;
   logic               buf_vld;
   logic signed [20:0] work_y [4];
   logic signed [20:0] buf_y  [4];

   logic signed [20:0] y_sel;
   logic signed [4:0]  w8_sel, w9_sel;
   logic signed [25:0] y_ext, w8_ext, w9_ext;
   logic signed [25:0] prod0, prod1;
   logic signed [27:0] sum0, sum1;
   logic               done, mid, launch_buf, launch_in, buf_load, drop;

   // Operand select for the current MAC step k: y[k] with w(4+k)8 / w(4+k)9.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      y_sel  = work_y[0];
      w8_sel = w48;
      w9_sel = w49;
      case (cnt)
         2'd1: begin
            y_sel  = work_y[1];
            w8_sel = w58;
            w9_sel = w59;
         end
         2'd2: begin
            y_sel  = work_y[2];
            w8_sel = w68;
            w9_sel = w69;
         end
         2'd3: begin
            y_sel  = work_y[3];
            w8_sel = w78;
            w9_sel = w79;
         end
         default: ;
      endcase
   end

   assign y_ext  = {{5{y_sel[20]}}, y_sel};
   assign w8_ext = {{21{w8_sel[4]}}, w8_sel};
   assign w9_ext = {{21{w9_sel[4]}}, w9_sel};
   assign prod0  = y_ext * w8_ext;
   assign prod1  = y_ext * w9_ext;
   assign sum0   = acc0 + {{2{prod0[25]}}, prod0};
   assign sum1   = acc1 + {{2{prod1[25]}}, prod1};

   // Job hand-off: the buffer always has priority over the live input at completion.
   assign done       = (state == ST_MAC) && (cnt == 2'd3);
   assign mid        = (state == ST_MAC) && !done;
   assign launch_buf = done && buf_vld;
   assign launch_in  = stg_2_rdy && ((state == ST_IDLE) || (done && !buf_vld));
   assign buf_load   = stg_2_rdy && ((mid && !buf_vld) || launch_buf);
   assign drop       = stg_2_rdy && mid && buf_vld;

   function automatic logic signed [27:0] relu(input logic signed [27:0] s);
      return (RELU_EN && s[27]) ? '0 : s;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= 2'd0;
         acc0      <= '0;
         acc1      <= '0;
         buf_vld   <= 1'b0;
         z0        <= '0;
         z1        <= '0;
         stg_3_rdy <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         stg_3_rdy <= done;
         if (done) begin
            z0 <= relu(sum0);
            z1 <= relu(sum1);
         end
         if (drop)
            overrun <= 1'b1;
         if (buf_load)
            buf_vld <= 1'b1;
         else if (launch_buf)
            buf_vld <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (launch_in) begin
                  state <= ST_MAC;
                  busy  <= 1'b1;
                  cnt   <= 2'd0;
                  acc0  <= '0;
                  acc1  <= '0;
               end
            end
            ST_MAC: begin
               if (done) begin
                  cnt  <= 2'd0;
                  acc0 <= '0;
                  acc1 <= '0;
                  if (!(launch_buf || launch_in)) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  acc0 <= sum0;
                  acc1 <= sum1;
                  cnt  <= cnt + 2'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: vector data is only consumed when qualified by state/buf_vld, so it carries no reset.
   always_ff @(posedge clk) begin
      if (launch_buf) begin
         work_y <= buf_y;
      end else if (launch_in) begin
         work_y[0] <= y0;
         work_y[1] <= y1;
         work_y[2] <= y2;
         work_y[3] <= y3;
      end
      if (buf_load) begin
         buf_y[0] <= y0;
         buf_y[1] <= y1;
         buf_y[2] <= y2;
         buf_y[3] <= y3;
      end
   end

endmodule

// File: doc/dnn_out_stage.md
DNN_OUT_STAGE -- requirements
Module: dnn_out_stage

Interface
REQ-001 Parameter RELU_EN, default 1: 1 clamps negative outputs to 0, 0 passes signed sums through.
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 stg_2_rdy  input  1  hidden-layer result valid; asserted for each cycle y0..y3 carry a new vector.
REQ-005 y0, y1, y2, y3  input  21 each, signed  hidden-node activations from the preceding dnn stage.
REQ-006 w48, w58, w68, w78  input  5 each, signed  weights from hidden nodes 4..7 to output node 8.
REQ-007 w49, w59, w69, w79  input  5 each, signed  weights from hidden nodes 4..7 to output node 9.
REQ-008 z0, z1  output  28 each, signed  output-node 8 and 9 results.
REQ-009 stg_3_rdy  output  1  one-cycle pulse marking new z0/z1.
REQ-010 busy  output  1  high while a vector is being accumulated.
REQ-011 overrun  output  1  sticky flag: an accepted-stage vector was dropped.

Function
REQ-012 The block uses two states, IDLE and MAC, plus a 2-bit index cnt and a one-entry holding buffer (buf_vld, buf_y0..buf_y3).
REQ-013 In IDLE with stg_2_rdy=1 at an edge, the block captures y0..y3 into working registers, clears both accumulators, sets cnt=0 and enters MAC.
REQ-014 In MAC, each edge adds y[cnt]*w[cnt]8 to acc0 and y[cnt]*w[cnt]9 to acc1 and increments cnt (k=0..3 maps to y0..y3 and w4k..w7k).
REQ-015 Products are 26-bit signed (21x5); accumulators and z0/z1 are 28-bit signed; sign extension is used throughout; no saturation is required because the sum cannot overflow 28 bits.
REQ-016 Weights are sampled live during MAC cycles; the integrator holds them stable while busy=1.
REQ-017 At the MAC edge with cnt=3, the block loads z0/z1 with the final sums and asserts stg_3_rdy for exactly the following cycle.
REQ-018 When RELU_EN=1, a final sum <=0 is loaded as 0.
REQ-019 Latency is 4 edges from the edge sampling stg_2_rdy to the edge raising stg_3_rdy; z0/z1 hold their value until the next completion.
REQ-020 busy=1 exactly while state=MAC.
REQ-021 stg_2_rdy=1 during MAC with buf_vld=0 stores y0..y3 into the buffer and sets buf_vld.
REQ-022 stg_2_rdy=1 during MAC with buf_vld=1 drops the new vector and sets overrun; overrun clears only on reset.
REQ-023 At the completion edge, if buf_vld=1 the buffer is launched as the next job, with state remaining MAC, cnt=0 and accumulators cleared.
REQ-024 At the completion edge, if buf_vld=0 and stg_2_rdy=1, the direct input is launched as the next job.
REQ-025 At the completion edge, if neither a buffered nor a direct vector is present, the block returns to IDLE.
REQ-026 If buf_vld=1 and stg_2_rdy=1 at the completion edge, the buffer launches and the new input refills the buffer; overrun is not set.
REQ-027 Sustained throughput is one vector per 4 cycles, back-to-back with no idle cycle.

Reset
REQ-028 rst_n=0 forces, asynchronously: state=IDLE, cnt=0, acc0=acc1=0, buf_vld=0, z0=z1=0, stg_3_rdy=0, busy=0, overrun=0.
REQ-029 Reset during MAC discards the in-flight and buffered vectors; no stg_3_rdy follows the reset release.
REQ-030 After rst_n rises, the first stg_2_rdy sampled at a rising edge is accepted.

Verification
REQ-031 Basic: y=(1,2,3,4), w48..w78=(1,1,1,1), w49..w79=(-1,-1,-1,-1), RELU_EN=1, one-cycle stg_2_rdy -> stg_3_rdy 4 edges later, z0=10, z1=0, busy high for 4 cycles.
REQ-032 No ReLU: same stimulus with RELU_EN=0 -> z0=10, z1=-10.
REQ-033 Extremes: y all =1048575, all weights 15 -> z0=z1=62914500; all weights -16 with RELU_EN=0 -> z0=z1=-67108800.
REQ-034 Streaming: stg_2_rdy held high for 12 cycles with distinct vectors.
  -> The vector accepted in IDLE and the vector written to the buffer by the first MAC-cycle stg_2_rdy complete back-to-back, 4 cycles apart.
  -> Each remaining vector presented while the buffer is full is dropped; each vector that coincides with a completion edge refills the buffer and completes in turn.
  -> overrun=1 after the first drop and stays set.
  -> Every completed z0/z1 matches a golden model of exactly the accepted vectors.
REQ-035 Simultaneous event: buffer full while stg_2_rdy=1 at the completion edge -> buffered vector completes next, the incoming vector completes after it, overrun stays 0.
REQ-036 Reset mid-MAC: rst_n pulled low at cnt=2 -> all outputs 0 immediately; no stg_3_rdy after release; a new vector then completes normally with latency 4.
